// File: rtl/fb_ram_banked.sv
// Banked framebuffer: port A is a fixed-latency display read, port B is a handshaked draw port.
// Define FB_XOR_EN to enable XOR read-modify-write on op 10; otherwise op 10 acts as WRITE.
module fb_ram_banked #(
   parameter int WIDTH   = 320,
   parameter int HEIGHT  = 200,
   parameter int BPP     = 1,
   parameter int BANK_AW = 14,
   localparam int XW     = $clog2(WIDTH),
   localparam int YW     = $clog2(HEIGHT)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [XW-1:0]  x_a,
   input  logic [YW-1:0]  y_a,
   output logic [BPP-1:0] out_a,
   input  logic [XW-1:0]  x_b,
   input  logic [YW-1:0]  y_b,
   input  logic [1:0]     op_b,
   input  logic [BPP-1:0] in_b,
   input  logic           req_b,
   output logic           rdy_b,
   output logic [BPP-1:0] out_b,
   output logic           out_vld_b,
   output logic           err_b
);
   localparam int NPIX   = WIDTH * HEIGHT;
   localparam int LW     = $clog2(NPIX);
   localparam int BWORDS = 1 << BANK_AW;
   localparam int NBANK  = (NPIX + BWORDS - 1) / BWORDS;
   localparam int AW     = (LW > BANK_AW) ? LW : BANK_AW + 1;
   localparam int BSW    = AW - BANK_AW;
   localparam int NSLOT  = 1 << BSW;

`ifdef FB_XOR_EN
   typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_OUT, S_WR, S_RMW_WAIT, S_RMW_WR} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_OUT, S_WR} state_t;
`endif

   function automatic logic [AW-1:0] lin_of(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return AW'(x) + AW'(y) * AW'(WIDTH);
   endfunction

   logic [BPP-1:0]     rd_a_all [NSLOT];
   logic [BPP-1:0]     rd_b_all [NSLOT];

   // Port A address decode
   logic [AW-1:0]      lin_a;
   logic               a_ok;
   logic [BSW-1:0]     bank_a;
   logic [BANK_AW-1:0] word_a;
   logic               a_ok_reg;
   logic [BSW-1:0]     a_bank_reg;

   assign lin_a  = lin_of(x_a, y_a);
   assign a_ok   = (32'(x_a) < WIDTH) && (32'(y_a) < HEIGHT);
   assign bank_a = lin_a[AW-1:BANK_AW];
   assign word_a = lin_a[BANK_AW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_ok_reg   <= 1'b0;
         a_bank_reg <= '0;
         out_a      <= '0;
      end else begin
         a_ok_reg   <= a_ok;
         a_bank_reg <= bank_a;
         out_a      <= a_ok_reg ? rd_a_all[a_bank_reg] : '0;
      end
   end

   // Port B decode and FSM
   logic [AW-1:0]      lin_b;
   logic               b_ok;
   logic               accept;
   state_t             state_reg, state_next;
   logic [BSW-1:0]     b_bank_reg;
   logic [BANK_AW-1:0] b_word_reg;
   logic [BPP-1:0]     b_in_reg;
   logic [BPP-1:0]     rd_b_sel;
   logic               b_en, b_we, out_load;
   logic [BPP-1:0]     b_wdata;

   assign lin_b    = lin_of(x_b, y_b);
   assign b_ok     = (32'(x_b) < WIDTH) && (32'(y_b) < HEIGHT);
   assign accept   = req_b && rdy_b;
   assign rd_b_sel = rd_b_all[b_bank_reg];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept && b_ok) begin
               case (op_b)
                  2'b01:   state_next = S_WR;
`ifdef FB_XOR_EN
                  2'b10:   state_next = S_RMW_WAIT;
`else
                  2'b10:   state_next = S_WR;
`endif
                  default: state_next = S_RD_WAIT;
               endcase
            end
         end
         S_RD_WAIT:  state_next = S_RD_OUT;
         S_RD_OUT:   state_next = S_IDLE;
         S_WR:       state_next = S_IDLE;
`ifdef FB_XOR_EN
         S_RMW_WAIT: state_next = S_RMW_WR;
         S_RMW_WR:   state_next = S_IDLE;
`endif
         default:    state_next = S_IDLE;
      endcase
   end

   always_comb begin
      rdy_b    = 1'b0;
      b_en     = 1'b0;
      b_we     = 1'b0;
      out_load = 1'b0;
      b_wdata  = b_in_reg;
      case (state_reg)
         S_IDLE:     rdy_b = 1'b1;
         S_RD_WAIT:  b_en  = 1'b1;
         S_RD_OUT:   out_load = 1'b1;
         S_WR: begin
            b_en = 1'b1;
            b_we = 1'b1;
         end
`ifdef FB_XOR_EN
         S_RMW_WAIT: b_en = 1'b1;
         S_RMW_WR: begin
            b_en     = 1'b1;
            b_we     = 1'b1;
            out_load = 1'b1;
            b_wdata  = rd_b_sel ^ b_in_reg;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         b_bank_reg <= '0;
         b_word_reg <= '0;
         b_in_reg   <= '0;
         out_b      <= '0;
         out_vld_b  <= 1'b0;
         err_b      <= 1'b0;
      end else begin
         err_b     <= accept && !b_ok;
         out_vld_b <= out_load;
         if (accept) begin
            b_bank_reg <= lin_b[AW-1:BANK_AW];
            b_word_reg <= lin_b[BANK_AW-1:0];
            b_in_reg   <= in_b;
         end
         if (out_load) out_b <= rd_b_sel;
      end
   end

   // Read-first banks; only the addressed bank is enabled on either port
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_bank
         if (gi < NBANK) begin : g_ram
            logic [BPP-1:0] mem [BWORDS];
            logic [BPP-1:0] rd_a_reg, rd_b_reg;
            logic           en_a, en_b;
            assign en_a = a_ok && (bank_a == BSW'(gi));
            assign en_b = b_en && (b_bank_reg == BSW'(gi));
            always_ff @(posedge clk) begin
               if (en_a) rd_a_reg <= mem[word_a];
               if (en_b) begin
                  rd_b_reg <= mem[b_word_reg];
                  if (b_we) mem[b_word_reg] <= b_wdata;
               end
            end
            assign rd_a_all[gi] = rd_a_reg;
            assign rd_b_all[gi] = rd_b_reg;
         end else begin : g_none
            assign rd_a_all[gi] = '0;
            assign rd_b_all[gi] = '0;
         end
      end
   endgenerate
endmodule

// File: tb/tb_fb_ram_banked.sv
// Directed bench for fb_ram_banked: scoreboard queues for port B read data and port A scan-out.
module tb_fb_ram_banked;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] x_a = '0, x_b = '0;
   logic [7:0] y_a = '0, y_b = '0;
   logic [1:0] op_b = '0;
   logic       in_b = 1'b0, req_b = 1'b0;
   logic       out_a, rdy_b, out_b, out_vld_b, err_b;

   int   checks = 0;
   int   errors = 0;
   logic exp_b_q [$];
   logic exp_a_q [$];

   fb_ram_banked dut (
      .clk(clk), .reset(reset),
      .x_a(x_a), .y_a(y_a), .out_a(out_a),
      .x_b(x_b), .y_b(y_b), .op_b(op_b), .in_b(in_b), .req_b(req_b),
      .rdy_b(rdy_b), .out_b(out_b), .out_vld_b(out_vld_b), .err_b(err_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one request; returns 1ns after the accepting edge
   task automatic issue(input logic [8:0] x, input logic [7:0] y, input logic [1:0] op, input logic d);
      x_b = x; y_b = y; op_b = op; in_b = d; req_b = 1'b1;
      chk("rdy_before_req", 32'(rdy_b), 1);
      @(posedge clk); #1;
      req_b = 1'b0;
      $display("txn op=%0d x=%0d y=%0d in=%0d", op, x, y, d);
   endtask

   task automatic wait_out(input string tag);
      int   lat = 0;
      logic e;
      chk({tag, "_rdy_busy"}, 32'(rdy_b), 0);
      while (!out_vld_b && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 2);
      e = exp_b_q.pop_front();
      chk({tag, "_data"}, 32'(out_b), 32'(e));
      chk({tag, "_rdy_back"}, 32'(rdy_b), 1);
      @(posedge clk); #1;
      chk({tag, "_vld_pulse"}, 32'(out_vld_b), 0);
   endtask

   task automatic write_px(input logic [8:0] x, input logic [7:0] y, input logic d);
      issue(x, y, 2'b01, d);
      chk("wr_rdy_busy", 32'(rdy_b), 0);
      @(posedge clk); #1;
      chk("wr_rdy_back", 32'(rdy_b), 1);
      chk("wr_no_vld", 32'(out_vld_b), 0);
   endtask

   task automatic read_px(input logic [8:0] x, input logic [7:0] y, input logic e);
      exp_b_q.push_back(e);
      issue(x, y, 2'b00, 1'b0);
      wait_out("read");
   endtask

   task automatic read_a(input logic [8:0] x, input logic [7:0] y, input logic e);
      logic g;
      x_a = x; y_a = y;
      exp_a_q.push_back(e);
      repeat (2) @(posedge clk);
      #1;
      g = exp_a_q.pop_front();
      chk("porta_read", 32'(out_a), 32'(g));
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", 32'(rdy_b), 1);
      chk("rst_out_a", 32'(out_a), 0);
      chk("rst_out_b", 32'(out_b), 0);
      chk("rst_vld", 32'(out_vld_b), 0);
      chk("rst_err", 32'(err_b), 0);
      #3 reset = 1'b0;
      @(posedge clk); #1;

      // Basic write then read
      write_px(5, 3, 1'b1);
      read_px(5, 3, 1'b1);

      // Same-address collision: port A sees the pre-write value
      issue(5, 3, 2'b01, 1'b0);
      x_a = 5; y_a = 3;
      exp_a_q.push_back(1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      begin
         logic g;
         g = exp_a_q.pop_front();
         chk("collision_old", 32'(out_a), 32'(g));
      end
      read_a(5, 3, 1'b0);

      // Fill row 0 alternating, then stream it out of port A
      for (int i = 0; i < 320; i++) write_px(9'(i), 0, (i % 2) == 0);
      y_a = 0;
      for (int i = 0; i <= 321; i++) begin
         logic g;
         if (i <= 320) begin
            x_a = 9'(i);
            exp_a_q.push_back((i < 320) && ((i % 2) == 0));
         end
         @(posedge clk); #1;
         if (i >= 1) begin
            g = exp_a_q.pop_front();
            chk("sweep", 32'(out_a), 32'(g));
         end
      end

      // First and last pixel, neighbours, port A out of range
      write_px(318, 199, 1'b0);
      write_px(319, 199, 1'b1);
      write_px(0, 0, 1'b1);
      write_px(0, 1, 1'b0);
      write_px(7, 7, 1'b0);
      read_px(319, 199, 1'b1);
      read_px(0, 0, 1'b1);
      read_px(318, 199, 1'b0);
      read_a(319, 199, 1'b1);
      read_a(0, 200, 1'b0);

`ifdef FB_XOR_EN
      exp_b_q.push_back(1'b0);
      issue(7, 7, 2'b10, 1'b1);
      wait_out("xor1");
      exp_b_q.push_back(1'b1);
      issue(7, 7, 2'b10, 1'b1);
      wait_out("xor2");
      read_px(7, 7, 1'b0);
`else
      issue(7, 7, 2'b10, 1'b1);
      chk("op10_rdy_busy", 32'(rdy_b), 0);
      @(posedge clk); #1;
      chk("op10_rdy_back", 32'(rdy_b), 1);
      chk("op10_no_vld", 32'(out_vld_b), 0);
      @(posedge clk); #1;
      chk("op10_no_vld2", 32'(out_vld_b), 0);
      read_px(7, 7, 1'b1);
`endif

      // Out-of-range requests
      issue(320, 0, 2'b01, 1'b1);
      chk("err_x_pulse", 32'(err_b), 1);
      chk("err_x_rdy", 32'(rdy_b), 1);
      chk("err_x_no_vld", 32'(out_vld_b), 0);
      @(posedge clk); #1;
      chk("err_x_clear", 32'(err_b), 0);
      read_px(0, 1, 1'b0);
      issue(0, 200, 2'b00, 1'b0);
      chk("err_y_pulse", 32'(err_b), 1);
      @(posedge clk); #1;
      chk("err_y_no_vld", 32'(out_vld_b), 0);

      // Reset while a request is in flight
`ifdef FB_XOR_EN
      issue(9, 9, 2'b10, 1'b1);
`else
      issue(9, 9, 2'b00, 1'b0);
`endif
      chk("inflight_busy", 32'(rdy_b), 0);
      reset = 1'b1;
      #1;
      chk("inflight_rst_rdy", 32'(rdy_b), 1);
      chk("inflight_rst_vld", 32'(out_vld_b), 0);
      #2 reset = 1'b0;
      @(posedge clk); #1;
      chk("inflight_no_vld", 32'(out_vld_b), 0);
      @(posedge clk); #1;
      chk("inflight_no_vld2", 32'(out_vld_b), 0);
      read_px(319, 199, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
